// File: rtl/proto_msg_stack.sv
// Purpose: tracks protobuf message nesting (per-level remaining bytes + dependency path) over a decoded field stream.
// Latency: all outputs registered, one cycle after the causing edge; each cascade pop costs one cycle.
// Backpressure: ready is high only in ACTIVE; byte/field inputs are ignored while popping or in error.
module proto_msg_stack #(
    parameter int                         NUM_MSG_HIERARCHY = 3,
    parameter int                         IDENTIFIER_SIZE   = 8,
    parameter int                         LEN_WIDTH         = 16,
    parameter logic [IDENTIFIER_SIZE-1:0] ROOT_ID           = 8'hAA
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [LEN_WIDTH-1:0]                         start_len,
    input  logic                                         byte_valid,
    input  logic                                         field_valid,
    input  logic [IDENTIFIER_SIZE-1:0]                   field_id,
    input  logic                                         field_is_msg,
    input  logic [LEN_WIDTH-1:0]                         field_len,
    output logic                                         ready,
    output logic [$clog2(NUM_MSG_HIERARCHY+1)-1:0]       depth,
    output logic [NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0] path,
    output logic [LEN_WIDTH-1:0]                         top_remaining,
    output logic                                         msg_done,
    output logic                                         err,
    output logic [1:0]                                   err_code
);

    localparam int DW = $clog2(NUM_MSG_HIERARCHY + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_POP    = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [DW-1:0]              r_depth, w_depth_nxt;
    logic [IDENTIFIER_SIZE-1:0] r_path     [NUM_MSG_HIERARCHY];
    logic [IDENTIFIER_SIZE-1:0] w_path_nxt [NUM_MSG_HIERARCHY];
    logic [LEN_WIDTH-1:0]       r_rem      [NUM_MSG_HIERARCHY];
    logic [LEN_WIDTH-1:0]       w_rem_nxt  [NUM_MSG_HIERARCHY];
    logic [LEN_WIDTH-1:0]       w_rem_dec  [NUM_MSG_HIERARCHY];
    logic                       r_msg_done, w_msg_done_nxt;
    logic                       r_err, w_err_nxt;
    logic [1:0]                 r_err_code, w_err_code_nxt;
    logic [LEN_WIDTH-1:0]       w_top_rem;     // stored rem at level depth-1
    logic [LEN_WIDTH-1:0]       w_below_rem;   // stored rem at level depth-2 (new top after a pop)
    logic [LEN_WIDTH-1:0]       w_parent_rem;  // rem at level depth-1 after this cycle's byte
    logic                       w_push;

    assign w_push = field_valid && field_is_msg;

    // Byte decrement of every active level, plus views of the top two levels.
    always_comb begin
        w_top_rem    = '0;
        w_below_rem  = '0;
        w_parent_rem = '0;
        for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
            w_rem_dec[k] = (byte_valid && (k < int'(r_depth))) ? r_rem[k] - LEN_WIDTH'(1) : r_rem[k];
            if (k + 1 == int'(r_depth)) begin
                w_top_rem    = r_rem[k];
                w_parent_rem = w_rem_dec[k];
            end
            if (k + 2 == int'(r_depth)) begin
                w_below_rem = r_rem[k];
            end
        end
    end

    // Next-state and datapath update; start from IDLE or ERROR reinitialises every level.
    always_comb begin
        w_state_nxt    = r_state;
        w_depth_nxt    = r_depth;
        w_path_nxt     = r_path;
        w_rem_nxt      = r_rem;
        w_msg_done_nxt = 1'b0;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    w_err_nxt      = 1'b0;
                    w_err_code_nxt = 2'b00;
                    for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
                        w_path_nxt[k] = '0;
                        w_rem_nxt[k]  = '0;
                    end
                    if (start_len == '0) begin
                        // Empty message completes immediately without ever becoming active.
                        w_msg_done_nxt = 1'b1;
                        w_depth_nxt    = '0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_path_nxt[0] = ROOT_ID;
                        w_rem_nxt[0]  = start_len;
                        w_depth_nxt   = DW'(1);
                        w_state_nxt   = S_ACTIVE;
                    end
                end else if (r_state == S_IDLE && byte_valid) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b11;
                    w_state_nxt    = S_ERROR;
                end
            end
            S_ACTIVE: begin
                if (w_push && int'(r_depth) == NUM_MSG_HIERARCHY) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b01;
                    w_state_nxt    = S_ERROR;
                end else if (w_push && field_len > w_parent_rem) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = 2'b10;
                    w_state_nxt    = S_ERROR;
                end else begin
                    w_rem_nxt = w_rem_dec;
                    if (w_push) begin
                        // Child counter loads unmodified: the concurrent byte belongs to the parents.
                        for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
                            if (k == int'(r_depth)) begin
                                w_path_nxt[k] = field_id;
                                w_rem_nxt[k]  = field_len;
                            end
                        end
                        w_depth_nxt = r_depth + DW'(1);
                        if (field_len == '0) begin
                            w_state_nxt = S_POP;
                        end
                    end else if (w_parent_rem == '0) begin
                        w_state_nxt = S_POP;
                    end
                end
            end
            S_POP: begin
                for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
                    if (k + 1 == int'(r_depth)) begin
                        w_path_nxt[k] = '0;
                        w_rem_nxt[k]  = '0;
                    end
                end
                w_depth_nxt = r_depth - DW'(1);
                if (r_depth == DW'(1)) begin
                    w_msg_done_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (w_below_rem == '0) begin
                    w_state_nxt = S_POP;
                end else begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any message without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_depth    <= '0;
            r_path     <= '{default: '0};
            r_rem      <= '{default: '0};
            r_msg_done <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_depth    <= w_depth_nxt;
            r_path     <= w_path_nxt;
            r_rem      <= w_rem_nxt;
            r_msg_done <= w_msg_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Flatten the path into the dependency-table layout, root in the low bits.
    always_comb begin
        path = '0;
        for (int k = 0; k < NUM_MSG_HIERARCHY; k++) begin
            path[k*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = r_path[k];
        end
    end

    assign ready         = (r_state == S_ACTIVE);
    assign depth         = r_depth;
    assign top_remaining = w_top_rem;
    assign msg_done      = r_msg_done;
    assign err           = r_err;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_proto_msg_stack.sv
// Purpose: directed self-checking bench for proto_msg_stack.
// Latency: inputs applied before a rising edge, outputs sampled 1 time unit after it.
// Backpressure: stimulus only drives byte/field strobes in cycles where ready is expected high.
module tb_proto_msg_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] start_len;
    logic        byte_valid;
    logic        field_valid;
    logic [7:0]  field_id;
    logic        field_is_msg;
    logic [15:0] field_len;
    logic        ready;
    logic [1:0]  depth;
    logic [23:0] path;
    logic [15:0] top_remaining;
    logic        msg_done;
    logic        err;
    logic [1:0]  err_code;

    int n_total = 0;
    int n_pass  = 0;

    proto_msg_stack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_len     (start_len),
        .byte_valid    (byte_valid),
        .field_valid   (field_valid),
        .field_id      (field_id),
        .field_is_msg  (field_is_msg),
        .field_len     (field_len),
        .ready         (ready),
        .depth         (depth),
        .path          (path),
        .top_remaining (top_remaining),
        .msg_done      (msg_done),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock with the given strobes, then strobes return low.
    task automatic cyc(input logic bv, input logic fv, input logic im,
                       input logic [7:0] id, input logic [15:0] ln);
        byte_valid   = bv;
        field_valid  = fv;
        field_is_msg = im;
        field_id     = id;
        field_len    = ln;
        @(posedge clk);
        #1;
        byte_valid   = 1'b0;
        field_valid  = 1'b0;
        field_is_msg = 1'b0;
        field_id     = 8'h00;
        field_len    = 16'h0000;
    endtask

    task automatic do_start(input logic [15:0] len);
        start     = 1'b1;
        start_len = len;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_len = 16'h0000;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; start_len = '0;
        byte_valid = 1'b0; field_valid = 1'b0; field_is_msg = 1'b0;
        field_id = '0; field_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_depth", depth, 0);
        chk("rst_path", path, 0);
        chk("rst_top", top_remaining, 0);
        chk("rst_done", msg_done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nested decode: 8-byte root, child BB (6) on byte 2, grandchild CC (2) on byte 4.
        do_start(16'd8);
        chk("nest_start_depth", depth, 1);
        chk("nest_start_path", path, 24'h0000AA);
        chk("nest_start_top", top_remaining, 8);
        chk("nest_start_ready", ready, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'hBB, 16'd6);
        chk("nest_b2_depth", depth, 2);
        chk("nest_b2_top", top_remaining, 6);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 8'hCC, 16'd2);
        chk("nest_b4_path", path, 24'hCCBBAA);
        chk("nest_b4_depth", depth, 3);
        chk("nest_b4_top", top_remaining, 2);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("nest_b6_ready", ready, 0);
        chk("nest_b6_depth", depth, 3);
        idle_cyc();
        chk("nest_pop1_depth", depth, 2);
        chk("nest_pop1_top", top_remaining, 2);
        chk("nest_pop1_path", path, 24'h00BBAA);
        chk("nest_pop1_ready", ready, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("nest_b7_top", top_remaining, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("nest_b8_ready", ready, 0);
        chk("nest_b8_depth", depth, 2);
        idle_cyc();
        chk("nest_pop2_depth", depth, 1);
        chk("nest_pop2_done", msg_done, 0);
        chk("nest_pop2_ready", ready, 0);
        idle_cyc();
        chk("nest_pop3_depth", depth, 0);
        chk("nest_pop3_done", msg_done, 1);
        chk("nest_pop3_path", path, 0);
        idle_cyc();
        chk("nest_done_clear", msg_done, 0);

        // Zero-length top-level message.
        do_start(16'd0);
        chk("zero_done", msg_done, 1);
        chk("zero_depth", depth, 0);
        chk("zero_ready", ready, 0);
        idle_cyc();
        chk("zero_done_clear", msg_done, 0);

        // Depth overflow, then recovery via start.
        do_start(16'd10);
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 16'd5);
        cyc(1'b0, 1'b1, 1'b1, 8'h22, 16'd3);
        chk("ovf_depth3", depth, 3);
        cyc(1'b0, 1'b1, 1'b1, 8'h33, 16'd1);
        chk("ovf_err", err, 1);
        chk("ovf_code", err_code, 2'b01);
        chk("ovf_ready", ready, 0);
        idle_cyc();
        chk("ovf_err_sticky", err, 1);
        do_start(16'd4);
        chk("ovf_rec_err", err, 0);
        chk("ovf_rec_code", err_code, 0);
        chk("ovf_rec_depth", depth, 1);
        chk("ovf_rec_path", path, 24'h0000AA);
        chk("ovf_rec_ready", ready, 1);

        // Child longer than what remains of the parent after this byte.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 8'h44, 16'd5);
        chk("long_err", err, 1);
        chk("long_code", err_code, 2'b10);

        // Child exactly filling the parent, pushed with a byte in the same cycle.
        do_start(16'd4);
        cyc(1'b1, 1'b1, 1'b1, 8'h55, 16'd3);
        chk("fit_err", err, 0);
        chk("fit_depth", depth, 2);
        chk("fit_top", top_remaining, 3);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("fit_pop_ready", ready, 0);
        idle_cyc();
        chk("fit_pop1_depth", depth, 1);
        idle_cyc();
        chk("fit_pop2_done", msg_done, 1);
        chk("fit_pop2_depth", depth, 0);

        // Empty child pops the next cycle; non-message field changes nothing.
        do_start(16'd5);
        cyc(1'b0, 1'b1, 1'b1, 8'h66, 16'd0);
        chk("empty_depth", depth, 2);
        chk("empty_path", path, 24'h0066AA);
        chk("empty_ready", ready, 0);
        idle_cyc();
        chk("empty_pop_depth", depth, 1);
        chk("empty_pop_path", path, 24'h0000AA);
        chk("empty_pop_top", top_remaining, 5);
        chk("empty_pop_ready", ready, 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h77, 16'd2);
        chk("plain_depth", depth, 1);
        chk("plain_top", top_remaining, 5);

        // Asynchronous reset in the middle of nesting.
        cyc(1'b0, 1'b1, 1'b1, 8'h88, 16'd2);
        chk("arst_pre_depth", depth, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_depth", depth, 0);
        chk("arst_path", path, 0);
        chk("arst_top", top_remaining, 0);
        chk("arst_ready", ready, 0);
        chk("arst_err", err, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("arst_no_done", msg_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte while idle, then a one-byte message.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("idle_byte_err", err, 1);
        chk("idle_byte_code", err_code, 2'b11);
        do_start(16'd1);
        chk("one_err", err, 0);
        chk("one_depth", depth, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        chk("one_pop_ready", ready, 0);
        idle_cyc();
        chk("one_done", msg_done, 1);
        chk("one_depth0", depth, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
